fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and address width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-003 SHALL have port clk  in  1: clock.
REQ-004 SHALL have port rstn  in  1: reset, synchronous, active-low.
REQ-005 SHALL have port i_flush  in  1: redirect; discard all queued and in-flight fetches.
REQ-006 SHALL have port i_im_arvalid  in  1: snooped IM read-address valid.
REQ-007 SHALL have port i_im_arready  in  1: snooped IM read-address ready.
REQ-008 SHALL have port i_im_araddr  in  XLEN: snooped fetch address (PC).
REQ-009 SHALL have port i_im_rvalid  in  1: IM read-data valid.
REQ-010 SHALL have port o_im_rready  out  1: IM read-data ready.
REQ-011 SHALL have port i_im_rdata  in  XLEN: instruction word.
REQ-012 SHALL have port i_im_rresp  in  2: read response; 0 is OKAY, nonzero is an error.
REQ-013 SHALL have port o_if_valid  out  1: instruction available to decode.
REQ-014 SHALL have port i_if_ready  in  1: decode accepts.
REQ-015 SHALL have port o_if_instr  out  XLEN: instruction.
REQ-016 SHALL have port o_if_pc  out  XLEN: PC of the instruction.
REQ-017 SHALL have port o_if_fault  out  1: fetch error flag.
REQ-018 SHALL have port o_stall  out  1: to the PC stage; halt address issue.

Function
REQ-019 SHALL allocate the tail entry and store i_im_araddr on an AR handshake (arvalid and arready); allocation is in order.
REQ-020 SHALL fill the oldest unfilled entry on an R handshake (rvalid and rready); storage is rdata, with fault = (rresp != 0).
REQ-021 SHALL replace instr with the NOP constant 0x00000013 on a faulted entry; o_if_fault=1.
REQ-022 SHALL drive o_if_valid=1 iff the head entry is filled; o_if_instr, o_if_pc and o_if_fault come from head registers, with no rdata-to-output bypass.
REQ-023 SHALL give a minimum latency of 1 cycle: R handshake at cycle N, o_if_valid at N+1.
REQ-024 SHALL free the head on an output handshake (o_if_valid and i_if_ready); o_if_* SHALL hold stable while valid and not ready.
REQ-025 SHALL keep count (allocated entries, 0..DEPTH) unchanged on same-cycle allocate and free; count may reach DEPTH.
REQ-026 SHALL drive o_stall=1 when count + drop_cnt == DEPTH; combinational from registered state.
REQ-027 SHALL drive o_im_rready=1 when any unfilled entry exists or drop_cnt>0; otherwise 0.
REQ-028 SHALL on i_flush, at the next edge: count, pointers and valid clear; drop_cnt += unfilled allocated entries, including an AR handshake in the flush cycle.
REQ-029 SHALL treat an R handshake in the flush cycle as already consumed, so it is not counted in drop_cnt.
REQ-030 SHALL decrement drop_cnt on an R handshake while drop_cnt>0; that response SHALL be discarded, with no fill.
REQ-031 SHALL allocate normally on an AR handshake after flush while drop_cnt>0; drops always match the oldest responses.
REQ-032 SHALL ignore an AR handshake while o_stall=1 and flag it via a simulation assertion; the upstream stage SHALL honour o_stall.
REQ-033 SHALL ignore an output handshake in the flush cycle, since flush dominates.
REQ-034 SHALL never let drop_cnt exceed DEPTH; its width is clog2(DEPTH)+1.
REQ-035 SHALL wrap pointers modulo DEPTH.

Reset
REQ-036 SHALL on rstn=0 at a clock edge: count=0, drop_cnt=0, pointers=0, all entries unfilled.
REQ-037 SHALL hold reset values o_if_valid=0, o_im_rready=0, o_stall=0, o_if_instr=0, o_if_pc=0, o_if_fault=0 while rstn=0 and the cycle after.
REQ-038 SHALL treat reset mid-operation as abandoning in-flight responses; the IM is reset concurrently.

Structure
REQ-039 SHALL take the NOP constant (0x00000013) and the rresp encoding enum (OKAY, EXOKAY, SLVERR, DECERR) from riscv_pkg.
REQ-040 SHALL use no sub-module; the queue is an inline register array with pointers.

Verification
REQ-041 SHALL cover: ARs at 0x0, 0x4, 0x8, then R data A, B, C back-to-back with ready=1 -> outputs (0x0,A), (0x4,B), (0x8,C) on consecutive cycles, first valid 1 cycle after the first R.
REQ-042 SHALL cover: DEPTH=4 ARs, i_if_ready=0 -> o_stall=1 after the 4th; one pop -> o_stall=0 the same cycle count drops.
REQ-043 SHALL cover: 3 ARs with 1 response returned, then i_flush -> o_if_valid=0 next cycle, drop_cnt=2; next 2 responses discarded; AR 0x100 then response D -> output (0x100,D).
REQ-044 SHALL cover: rresp=2 with rdata 0xDEADBEEF -> o_if_instr=0x00000013, o_if_fault=1.
REQ-045 SHALL cover: i_if_ready toggling with simultaneous push/pop for 100 random cycles -> output order matches a scoreboard; count never exceeds DEPTH.
REQ-046 SHALL cover: rstn=0 asserted with 2 entries in flight -> all outputs 0 the next cycle; later R handshakes are not accepted.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and AXI-style response encodings used by the fetch path.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } rresp_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction fetch queue: snoops IM address handshakes, pairs returning
// read data with queued PCs, and discards responses orphaned by a redirect.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_flush,
    input  logic            i_im_arvalid,
    input  logic            i_im_arready,
    input  logic [XLEN-1:0] i_im_araddr,
    input  logic            i_im_rvalid,
    output logic            o_im_rready,
    input  logic [XLEN-1:0] i_im_rdata,
    input  logic [1:0]      i_im_rresp,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    output logic            o_if_fault,
    output logic            o_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] fault_q;
    logic [PW-1:0]    head_q, tail_q, fill_q;
    logic [CW-1:0]    count_q, pend_q, drop_q;

    logic ar_hs, r_hs, fill, pop, resp_err;

    assign o_stall     = (count_q + drop_q) == CW'(DEPTH);
    assign o_im_rready = (pend_q != '0) || (drop_q != '0);
    assign o_if_valid  = filled_q[head_q];
    assign o_if_instr  = instr_q[head_q];
    assign o_if_pc     = pc_q[head_q];
    assign o_if_fault  = fault_q[head_q];

    assign ar_hs    = i_im_arvalid && i_im_arready && !o_stall;
    assign r_hs     = i_im_rvalid && o_im_rready;
    assign fill     = r_hs && (drop_q == '0);
    assign pop      = o_if_valid && i_if_ready && !i_flush;
    assign resp_err = rresp_e'(i_im_rresp) != RESP_OKAY;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q <= '0;
            fault_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
        end else if (i_flush) begin
            // Every still-unfilled request (plus one issued this cycle) owes a response
            // that must be dropped; a response arriving now retires the oldest debt.
            drop_q   <= drop_q + pend_q + CW'(ar_hs) - CW'(r_hs);
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
        end else begin
            if (ar_hs) begin
                pc_q[tail_q] <= i_im_araddr;
                tail_q       <= tail_q + PW'(1);
            end
            if (r_hs && drop_q != '0)
                drop_q <= drop_q - CW'(1);
            if (fill) begin
                instr_q[fill_q]  <= resp_err ? XLEN'(NOP_INSTR) : i_im_rdata;
                fault_q[fill_q]  <= resp_err;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (pop) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(ar_hs) - CW'(pop);
            pend_q  <= pend_q + CW'(ar_hs) - CW'(fill);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && i_im_arvalid && i_im_arready)
            assert (!o_stall) else $error("fetch_buffer: AR handshake issued while o_stall");
    end

endmodule
